// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
package mult_div_pkg;

    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/mult_div_if.sv
// Launch/result bundle between the control unit and mult_div.
interface mult_div_if #(
    parameter int WIDTH = 32
);

    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start_mult, start_div, op_a, op_b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b,
        output hi, lo, busy, done, div_zero
    );

endinterface

// File: rtl/mult_div_booth_step.sv
// One radix-2 Booth iteration on the {product, multiplier, q-1} accumulator.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] mcand,
    output logic [2*WIDTH:0] acc_next
);

    logic [WIDTH:0] upper;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    // One guard bit keeps the most-negative multiplicand exact before the shift.
    always_comb begin
        upper = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        m_ext = {mcand[WIDTH-1], mcand};
        case (acc[1:0])
            2'b01:   sum = upper + m_ext;
            2'b10:   sum = upper - m_ext;
            default: sum = upper;
        endcase
        acc_next = {sum, acc[WIDTH:1]};
    end

endmodule

// File: rtl/mult_div.sv
// Multicycle signed multiply (Booth radix-2) / divide (restoring) unit writing HI/LO.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    mult_div_if.slave bus
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;

    logic [2*WIDTH:0]   acc_booth;
    logic [2*WIDTH:0]   acc_div;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    booth_step #(.WIDTH(WIDTH)) u_booth (
        .acc      (acc),
        .mcand    (mcand),
        .acc_next (acc_booth)
    );

    // Divide reuses acc as {remainder (WIDTH+1), quotient (WIDTH)}.
    always_comb begin
        abs_a   = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
        abs_b   = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, mcand};
        qbit    = ~diff[WIDTH];
        acc_div = {(qbit ? diff : shifted), acc[WIDTH-2:0], qbit};
        rem     = acc[2*WIDTH-1:WIDTH];
        quo     = acc[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_mult) begin
                        state  <= MULT;
                        busy_q <= 1'b1;
                        cnt    <= CNT_W'(ITERS - 1);
                        acc    <= {{WIDTH{1'b0}}, bus.op_b, 1'b0};
                        mcand  <= bus.op_a;
                        dz_q   <= 1'b0;
                    end else if (bus.start_div) begin
                        cnt  <= CNT_W'(ITERS - 1);
                        dz_q <= (bus.op_b == '0);
                        if (bus.op_b == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= DIV;
                            busy_q <= 1'b1;
                            acc    <= {{(WIDTH+1){1'b0}}, abs_a};
                            mcand  <= abs_b;
                            neg_q  <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                            neg_r  <= bus.op_a[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    acc <= acc_booth;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state        <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        {hi_q, lo_q} <= acc_booth[2*WIDTH:1];
                    end
                end
                DIV: begin
                    acc <= acc_div;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    hi_q   <= neg_r ? -rem : rem;
                    lo_q   <= neg_q ? -quo : quo;
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div against an arithmetic reference model.
module tb_mult_div;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // sm/sd: start strobes; inject: extra starts while busy and during DONE.
    task automatic run_op(input string tag, input bit sm, input bit sd,
                          input logic [31:0] a, input logic [31:0] b, input bit inject);
        longint sa, sb, res;
        bit     is_mult, dz;
        int     exp_done, exp_busy, done_cyc, busy_cnt;
        bit     overlap;

        is_mult = sm;
        dz      = !sm && sd && (b == 32'd0);
        sa      = longint'($signed(a));
        sb      = longint'($signed(b));
        if (is_mult) begin
            res    = sa * sb;
            exp_hi = res[63:32];
            exp_lo = res[31:0];
        end else if (!dz) begin
            res    = sa / sb;
            exp_lo = res[31:0];
            res    = sa % sb;
            exp_hi = res[31:0];
        end
        exp_dz   = dz;
        exp_done = is_mult ? 33 : (dz ? 1 : 34);
        exp_busy = is_mult ? 32 : (dz ? 0 : 33);

        @(negedge clk);
        bus.start_mult = sm;
        bus.start_div  = sd;
        bus.op_a       = a;
        bus.op_b       = b;
        @(posedge clk);
        #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = $urandom;
        bus.op_b       = $urandom;

        done_cyc = 0;
        busy_cnt = 0;
        overlap  = 1'b0;
        for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cyc = c;
            bus.start_mult = 1'b0;
            bus.start_div  = 1'b0;
            if (inject && c == 5) begin
                bus.start_mult = 1'b1;
                bus.start_div  = 1'b1;
                bus.op_a       = $urandom;
                bus.op_b       = $urandom;
            end
        end
        check({tag, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, ".busy_done_overlap"}, 64'(overlap), 64'd0);
        check({tag, ".hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, ".div_zero"}, 64'(bus.div_zero), 64'(exp_dz));

        if (inject) bus.start_mult = 1'b1;
        @(negedge clk);
        bus.start_mult = 1'b0;
        check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, ".idle_busy"}, 64'(bus.busy), 64'd0);
        if (inject) begin
            check({tag, ".hold_hi"}, 64'(bus.hi), 64'(exp_hi));
            check({tag, ".hold_lo"}, 64'(bus.lo), 64'(exp_lo));
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          kind;

        n_assert       = 0;
        n_fail         = 0;
        exp_hi         = '0;
        exp_lo         = '0;
        exp_dz         = 1'b0;
        rst_n          = 1'b0;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        repeat (3) @(negedge clk);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.div_zero", 64'(bus.div_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mult_small", 1'b1, 1'b0, 32'd7, -32'sd3, 1'b0);
        check("mult_small.hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_small.lo_const", 64'(bus.lo), 64'hFFFF_FFEB);
        run_op("mult_extreme", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("mult_extreme.hi_const", 64'(bus.hi), 64'h4000_0000);
        run_op("div_signed", 1'b0, 1'b1, -32'sd7, 32'd2, 1'b0);
        check("div_signed.lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
        run_op("preload", 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        run_op("div_zero", 1'b0, 1'b1, 32'd55, 32'd0, 1'b0);
        run_op("dz_clear", 1'b1, 1'b0, 32'd3, 32'd5, 1'b0);
        run_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("both_starts", 1'b1, 1'b1, -32'sd1000, 32'd0, 1'b0);
        run_op("busy_ignore", 1'b0, 1'b1, 32'd100000, -32'sd7, 1'b1);
        run_op("busy_ignore_m", 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);

        // Abort a multiply in its tenth cycle.
        @(negedge clk);
        bus.start_mult = 1'b1;
        bus.op_a       = 32'd99;
        bus.op_b       = 32'd77;
        @(posedge clk);
        #1;
        bus.start_mult = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.hi", 64'(bus.hi), 64'd0);
        check("midreset.lo", 64'(bus.lo), 64'd0);
        check("midreset.busy", 64'(bus.busy), 64'd0);
        check("midreset.done", 64'(bus.done), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset", 1'b1, 1'b0, -32'sd12345, 32'd678, 1'b0);

        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 4);
            ra   = $urandom;
            rb   = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 5)) - 32'd2;
            case (kind)
                0:       run_op("rnd_mult", 1'b1, 1'b0, ra, rb, 1'b0);
                1:       run_op("rnd_div", 1'b0, 1'b1, ra, rb, 1'b0);
                2:       run_op("rnd_both", 1'b1, 1'b1, ra, rb, 1'b0);
                3:       run_op("rnd_div0", 1'b0, 1'b1, ra, 32'd0, 1'b0);
                default: run_op("rnd_inject", 1'b0, 1'b1, ra, rb, 1'b1);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div.md
# mult_div

Multicycle signed multiply/divide unit for the processor datapath. It sits directly downstream of the ALU operand-A select stage and consumes the same selected operand A plus operand B. It serves MIPS `mult`/`div` by iterating for 32 cycles (Booth radix-2 multiply, restoring divide) and writes the HI/LO results. The control unit launches an operation and stalls on `busy` until `done`.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `start_mult`  in  1: start a signed multiply; sampled only in IDLE.
- `start_div`  in  1: start a signed divide; sampled only in IDLE.
- `op_a`  in  WIDTH: multiplicand or dividend (the selected operand A).
- `op_b`  in  WIDTH: multiplier or divisor.
- `hi`  out  WIDTH: product upper half, or remainder.
- `lo`  out  WIDTH: product lower half, or quotient.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse; HI/LO are valid in this cycle.
- `div_zero`  out  1: sticky flag, set when a divide had `op_b == 0`.

## Operation
- **States:** IDLE, MULT, DIV, FIX, DONE.
- **IDLE:**
  - `start_mult` takes priority over `start_div`.
  - On start, `op_a` and `op_b` are captured, the iteration counter is loaded with 31, and the FSM goes to MULT or DIV.
  - Operand changes after capture have no effect.
- **MULT (Booth radix-2):**
  - Accumulator is 2·WIDTH+1 bits (product:multiplier:q₋₁).
  - Each cycle, examine {q0, q₋₁}: 01 adds the multiplicand to the upper half, 10 subtracts it, 00/11 do nothing.
  - Then arithmetic-shift-right by 1.
  - After 32 iterations go to DONE with hi:lo = full 64-bit signed product.
- **DIV (restoring, on magnitudes):**
  - Each cycle, shift remainder:quotient left, subtract |divisor|, and restore if the result is negative; the quotient bit = !negative.
  - After 32 iterations go to FIX.
- **FIX:**
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend (truncation toward zero).
  - Then go to DONE.
- **Divide by zero:**
  - When `start_div` arrives with `op_b == 0`, go straight from IDLE to DONE.
  - HI/LO keep their previous values and `div_zero` is set.
- **Overflow case:** 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This is the natural wrap; no flag is raised.
- **`div_zero` clearing:** cleared when the next start is accepted.
- **DONE:** `done` = 1 for one cycle, then return to IDLE. A start is not accepted in DONE.
- **HI/LO registers:**
  - Written only on the edge that enters DONE.
  - Hold their value otherwise, including across ignored starts.
- **Ignored starts:** `start_*` while `busy` or in DONE is ignored; there is no queueing.

## Timing
- **Reset:** `rst_n` low forces asynchronously: state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, counter = 0.
- **Reset mid-operation:** the operation is aborted with no `done`, and HI/LO = 0.
- **Cycle 0 is the cycle in which a start is sampled.**
- **Multiply:**
  - `busy` = 1 in cycles 1–32.
  - `done` = 1 in cycle 33, with HI/LO valid.
- **Divide:**
  - `busy` = 1 in cycles 1–33 (cycle 33 is FIX).
  - `done` = 1 in cycle 34.
- **Divide by zero:**
  - `busy` = 0.
  - `done` = 1 and `div_zero` = 1 in cycle 1.
- **Back-to-back:** the earliest next accepted start is the cycle after `done`.
- **Output timing:**
  - `busy` is a registered state decode and is never high together with `done`.
  - All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **`mult_div_pkg`:**
  - The state enum (IDLE, MULT, DIV, FIX, DONE).
  - `ITERS = 32`.
  - The counter width `$clog2(ITERS)`.
- **Sub-module `booth_step`:** combinational. Takes the accumulator and multiplicand, returns the next accumulator. It is instantiated once.
- **Kept in the top level:** divider step, sign fix, FSM and HI/LO registers.

## Test plan
- **Small multiply:** `start_mult`, a = 7, b = −3 → done in cycle 33, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, busy high for exactly 32 cycles.
- **Extreme multiply:** a = 0x80000000, b = 0x80000000 → hi = 0x40000000, lo = 0x00000000.
- **Signed divide:** `start_div`, a = −7, b = 2 → done in cycle 34, lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1).
- **Divide by zero:**
  - Preload HI/LO with a multiply, then `start_div` with b = 0 → done and div_zero in cycle 1; HI/LO unchanged.
  - The next start clears `div_zero`.
- **Overflow and priority:**
  - Divide 0x80000000 by −1 → lo = 0x80000000, hi = 0.
  - Both starts in one cycle → multiply performed.
  - A start during busy → ignored; result and latency unaffected.
- **Reset mid-operation:** `rst_n` low in cycle 10 of a multiply → outputs 0 immediately; after release a new multiply completes correctly.
